// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets into sign-magnitude button/motion fields with a data_ready/read handshake.
// Optional inter-byte timeout is built only when PS2_MOUSE_TIMEOUT_EN is defined.
module ps2_mouse_packet #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       read,
   output logic       data_ready,
   output logic       left_button,
   output logic       middle_button,
   output logic       right_button,
   output logic [8:0] x_increment,
   output logic [8:0] y_increment,
   output logic [7:0] dropped_packets
);

   typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

   state_t     state_q, state_d;
   logic [7:0] b0_q;
   logic [7:0] x_q;
   logic       pending;
   logic       accept_b0;
   logic       accept_x;
   logic       complete;
   logic       tmo;
   state_t     eff_state;

   // Two's complement {sign, byte} to {direction, magnitude}; -256 clips to 255.
   function automatic logic [8:0] conv(input logic sign, input logic ovf, input logic [7:0] b);
      logic [8:0] neg;
      logic [7:0] mag;
      neg = 9'd256 - {1'b0, b};
      if (ovf)
         mag = 8'hFF;
      else if (!sign)
         mag = b;
      else if (neg[8])
         mag = 8'hFF;
      else
         mag = neg[7:0];
      return {sign, mag};
   endfunction

`ifdef PS2_MOUSE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;

   assign tmo = (state_q != WAIT_B0) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || state_q == WAIT_B0 || rx_valid || tmo)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   // On timeout the current byte is judged as if the FSM were already back in WAIT_B0.
   assign eff_state = tmo ? WAIT_B0 : state_q;

   always_comb begin
      state_d   = eff_state;
      accept_b0 = 1'b0;
      accept_x  = 1'b0;
      complete  = 1'b0;
      case (eff_state)
         WAIT_B0: begin
            if (rx_valid && rx_data[3]) begin
               accept_b0 = 1'b1;
               state_d   = WAIT_B1;
            end
         end
         WAIT_B1: begin
            if (rx_valid) begin
               accept_x = 1'b1;
               state_d  = WAIT_B2;
            end
         end
         WAIT_B2: begin
            if (rx_valid) begin
               complete = 1'b1;
               state_d  = WAIT_B0;
            end
         end
         default: state_d = WAIT_B0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= WAIT_B0;
         b0_q            <= '0;
         x_q             <= '0;
         pending         <= 1'b0;
         left_button     <= 1'b0;
         middle_button   <= 1'b0;
         right_button    <= 1'b0;
         x_increment     <= '0;
         y_increment     <= '0;
         dropped_packets <= '0;
      end else begin
         state_q <= state_d;
         if (accept_b0)
            b0_q <= rx_data;
         if (accept_x)
            x_q <= rx_data;
         if (complete) begin
            left_button   <= b0_q[0];
            right_button  <= b0_q[1];
            middle_button <= b0_q[2];
            x_increment   <= conv(b0_q[4], b0_q[6], x_q);
            y_increment   <= conv(b0_q[5], b0_q[7], rx_data);
            pending       <= 1'b1;
            if (pending && !read && dropped_packets != 8'hFF)
               dropped_packets <= dropped_packets + 8'd1;
         end else if (read) begin
            pending <= 1'b0;
         end
      end
   end

   assign data_ready = pending & ~read;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed and random packet traffic against a byte-level reference model of the packet assembler.
module tb_ps2_mouse_packet;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       read;
   logic       data_ready;
   logic       left_button, middle_button, right_button;
   logic [8:0] x_increment, y_increment;
   logic [7:0] dropped_packets;

   int n_checks = 0;
   int n_fail   = 0;

   ps2_mouse_packet #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .read(read),
      .data_ready(data_ready), .left_button(left_button), .middle_button(middle_button),
      .right_button(right_button), .x_increment(x_increment), .y_increment(y_increment),
      .dropped_packets(dropped_packets)
   );

   always #5 clk = ~clk;

   // reference model state
   int       m_n;          // bytes of the current packet already held
   int       m_g;          // idle cycles since last byte while mid-packet
   logic [7:0] m_b0, m_bx;
   logic     m_pending, m_l, m_m, m_r;
   logic [8:0] m_x, m_y;
   int       m_drop;

   function automatic logic [8:0] ref_conv(input logic sign, input logic ovf, input logic [7:0] b);
      int v, mag;
      v   = sign ? int'(b) - 256 : int'(b);
      mag = (v < 0) ? -v : v;
      if (ovf || mag > 255) mag = 255;
      return {sign, mag[7:0]};
   endfunction

   task automatic model_reset();
      m_n = 0; m_g = 0; m_b0 = 0; m_bx = 0; m_pending = 0;
      m_l = 0; m_m = 0; m_r = 0; m_x = 0; m_y = 0; m_drop = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d, input logic rd);
      int  n0;
      logic timed_out;
      n0 = m_n;
      timed_out = 1'b0;
`ifdef PS2_MOUSE_TIMEOUT_EN
      if (m_n != 0 && m_g == TMO - 1) begin
         m_n = 0;
         timed_out = 1'b1;
      end
`endif
      if (v) begin
         if (m_n == 0) begin
            if (d[3]) begin m_b0 = d; m_n = 1; end
         end else if (m_n == 1) begin
            m_bx = d; m_n = 2;
         end else begin
            m_l = m_b0[0]; m_r = m_b0[1]; m_m = m_b0[2];
            m_x = ref_conv(m_b0[4], m_b0[6], m_bx);
            m_y = ref_conv(m_b0[5], m_b0[7], d);
            if (m_pending && !rd && m_drop < 255) m_drop++;
            m_pending = 1'b1;
            m_n = 0;
            rd = 1'b0;
         end
      end
      if (rd) m_pending = 1'b0;
      m_g = (n0 == 0 || v || timed_out) ? 0 : m_g + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("data_ready", {31'd0, data_ready}, {31'd0, m_pending & ~read});
      chk("left", {31'd0, left_button}, {31'd0, m_l});
      chk("middle", {31'd0, middle_button}, {31'd0, m_m});
      chk("right", {31'd0, right_button}, {31'd0, m_r});
      chk("x_inc", {23'd0, x_increment}, {23'd0, m_x});
      chk("y_inc", {23'd0, y_increment}, {23'd0, m_y});
      chk("dropped", {24'd0, dropped_packets}, m_drop);
   endtask

   // Called at a negedge: drive, check combinational ready, clock, check registered outputs.
   task automatic cycle(input logic v, input logic [7:0] d, input logic rd);
      rx_valid = v; rx_data = d; read = rd;
      #1;
      chk("ready_comb", {31'd0, data_ready}, {31'd0, m_pending & ~rd});
      @(posedge clk);
      model_edge(v, d, rd);
      @(negedge clk);
      rx_valid = 1'b0; read = 1'b0;
      #1;
      check_all();
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      cycle(1'b1, a, 1'b0);
      cycle(1'b1, b, 1'b0);
      cycle(1'b1, c, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; read = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_all();
      reset = 1'b0;

      // basic packet, then read
      send(8'h09, 8'h05, 8'hFB);
      chk("basic_x", {23'd0, x_increment}, 32'h005);
      chk("basic_ready", {31'd0, data_ready}, 32'd1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("after_read", {31'd0, data_ready}, 32'd0);
      cycle(1'b0, 8'h00, 1'b1);   // read with nothing pending

      // saturation and overflow
      send(8'h38, 8'h00, 8'h00);
      chk("sat_x", {23'd0, x_increment}, 32'h1FF);
      chk("sat_y", {23'd0, y_increment}, 32'h1FF);
      cycle(1'b0, 8'h00, 1'b1);
      send(8'hC8, 8'h12, 8'h34);
      chk("ovf_x", {23'd0, x_increment}, 32'h0FF);
      chk("ovf_y", {23'd0, y_increment}, 32'h0FF);
      send(8'h18, 8'hFF, 8'h80);  // -1 and +128; also one drop
      cycle(1'b0, 8'h00, 1'b1);

      // resync on byte-0 bit 3
      cycle(1'b1, 8'h00, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      send(8'h0A, 8'h01, 8'h01);
      chk("resync_r", {31'd0, right_button}, 32'd1);
      chk("resync_x", {23'd0, x_increment}, 32'h001);
      cycle(1'b0, 8'h00, 1'b1);

      // overrun, then completion coinciding with read
      send(8'h0C, 8'h11, 8'h22);
      send(8'h29, 8'h33, 8'hF0);
      chk("ovr_drop", {24'd0, dropped_packets}, 32'd2);
      cycle(1'b1, 8'h0B, 1'b0);
      cycle(1'b1, 8'h44, 1'b0);
      cycle(1'b1, 8'h55, 1'b1);
      chk("ovr_drop_hold", {24'd0, dropped_packets}, 32'd2);
      chk("ovr_ready", {31'd0, data_ready}, 32'd1);
      cycle(1'b0, 8'h00, 1'b1);

      // inter-byte gap
      cycle(1'b1, 8'h08, 1'b0);
      cycle(1'b1, 8'h10, 1'b0);
      idle(20);
      send(8'h09, 8'h01, 8'h02);
      idle(2);
      cycle(1'b0, 8'h00, 1'b1);

      // reset mid-packet
      cycle(1'b1, 8'h09, 1'b0);
      cycle(1'b1, 8'h07, 1'b0);
      do_reset();
      chk("rst_drop", {24'd0, dropped_packets}, 32'd0);
      send(8'h0D, 8'h03, 8'h04);
      chk("post_rst_x", {23'd0, x_increment}, 32'h003);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic v, rd;
         logic [7:0] d;
         v  = ($urandom_range(0, 2) != 0);
         d  = 8'($urandom());
         if ($urandom_range(0, 3) != 0) d[3] = 1'b1;
         rd = ($urandom_range(0, 5) == 0);
         cycle(v, d, rd);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
